// File: rtl/mipi_csi_pkg.sv
// Shared DataID codes, header byte layout, ECC parity masks and decoder state for the CSI-2 RX path.
package mipi_csi_pkg;

    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_RAW8  = 6'h2A;
    localparam logic [5:0] DT_RAW10 = 6'h2B;
    localparam logic [5:0] DT_RAW12 = 6'h2C;
    localparam logic [5:0] DT_RAW14 = 6'h2D;

    localparam int HDR_DI_BYTE    = 0;
    localparam int HDR_WC_LO_BYTE = 1;
    localparam int HDR_WC_HI_BYTE = 2;
    localparam int HDR_ECC_BYTE   = 3;

    // Parity bit i is the XOR of the header bits selected by ECC_MASK[i] (bit 0 = DI[0]).
    localparam logic [23:0] ECC_MASK [6] = '{
        24'hF12CB7, 24'hF2555B, 24'h749A6D, 24'hB8E38E, 24'hDF03F0, 24'hEFFC00
    };

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_SKIP    = 2'd2
    } state_t;

    function automatic logic is_raw_long(input logic [5:0] dt);
        return (dt == DT_RAW8) || (dt == DT_RAW10) || (dt == DT_RAW12) || (dt == DT_RAW14);
    endfunction

endpackage

// File: rtl/mipi_csi_ecc_check.sv
// CSI-2 header ECC recompute and compare; detection only, no correction.
// Latency: combinational; backpressure: none.
module mipi_csi_ecc_check
    import mipi_csi_pkg::*;
(
    input  logic [23:0] hdr_bits,
    input  logic [7:0]  ecc_rx,
    output logic [5:0]  ecc_calc,
    output logic        ecc_match
);

    always_comb begin
        ecc_calc = '0;
        for (int i = 0; i < 6; i++) begin
            ecc_calc[i] = ^(hdr_bits & ECC_MASK[i]);
        end
    end

    assign ecc_match = (ecc_rx == {2'b00, ecc_calc});

endmodule

// File: rtl/mipi_csi_rx_packet_decoder_2lane.sv
// CSI-2 packet decoder: header check, short-packet pulses, 32-bit payload realignment.
// Latency: pulses 1 cycle, payload beat 2 cycles after header; backpressure: none.
module mipi_csi_rx_packet_decoder_2lane
    import mipi_csi_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        data_valid_i,
    input  logic [63:0] data_i,
    output logic        output_valid_o,
    output logic [63:0] data_o,
    output logic [2:0]  packet_type_o,
    output logic [15:0] packet_length_o,
    output logic        frame_start_o,
    output logic        frame_end_o,
    output logic        ecc_error_o,
    output logic        packet_error_o
);

    state_t      state_q, state_d;
    logic [13:0] beats_left_q, beats_left_d;
    logic [31:0] prev_hi_q;

    logic [7:0]  hdr_di;
    logic [15:0] hdr_wc;
    logic [7:0]  hdr_ecc;
    logic [16:0] wc_round;
    logic [5:0]  ecc_calc_unused;
    logic        ecc_ok;
    logic        accept_long;

    logic        out_vld_d, fs_d, fe_d, ecc_err_d, pkt_err_d;
    logic [63:0] out_dat_d;
    logic [2:0]  type_d;
    logic [15:0] len_d;

    assign hdr_di   = data_i[8*HDR_DI_BYTE +: 8];
    assign hdr_wc   = {data_i[8*HDR_WC_HI_BYTE +: 8], data_i[8*HDR_WC_LO_BYTE +: 8]};
    assign hdr_ecc  = data_i[8*HDR_ECC_BYTE +: 8];
    assign wc_round = {1'b0, hdr_wc} + 17'd7;

    mipi_csi_ecc_check u_ecc (
        .hdr_bits  ({hdr_wc, hdr_di}),
        .ecc_rx    (hdr_ecc),
        .ecc_calc  (ecc_calc_unused),
        .ecc_match (ecc_ok)
    );

    assign accept_long = ecc_ok && is_raw_long(hdr_di[5:0]) && (hdr_wc != 16'd0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (data_valid_i) begin
                    state_d = accept_long ? ST_PAYLOAD : ST_SKIP;
                end
            end
            ST_PAYLOAD: begin
                if (!data_valid_i) begin
                    state_d = ST_IDLE;
                end else if (beats_left_q == 14'd1) begin
                    state_d = ST_SKIP;
                end
            end
            ST_SKIP: begin
                if (!data_valid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_vld_d    = 1'b0;
        out_dat_d    = data_o;
        fs_d         = 1'b0;
        fe_d         = 1'b0;
        ecc_err_d    = 1'b0;
        pkt_err_d    = 1'b0;
        type_d       = packet_type_o;
        len_d        = packet_length_o;
        beats_left_d = beats_left_q;
        case (state_q)
            ST_IDLE: begin
                if (data_valid_i) begin
                    if (!ecc_ok) begin
                        ecc_err_d = 1'b1;
                    end else if (hdr_di[5:0] == DT_FS) begin
                        fs_d = 1'b1;
                    end else if (hdr_di[5:0] == DT_FE) begin
                        fe_d = 1'b1;
                    end else if (accept_long) begin
                        type_d       = hdr_di[2:0];
                        len_d        = hdr_wc;
                        beats_left_d = wc_round[16:3];
                    end
                end
            end
            ST_PAYLOAD: begin
                if (data_valid_i) begin
                    out_vld_d    = 1'b1;
                    out_dat_d    = {data_i[31:0], prev_hi_q};
                    beats_left_d = beats_left_q - 14'd1;
                end else if (beats_left_q == 14'd1) begin
                    // Last beat's payload lives entirely in the previous upper half.
                    out_vld_d    = 1'b1;
                    out_dat_d    = {32'h0, prev_hi_q};
                    beats_left_d = '0;
                end else begin
                    pkt_err_d    = 1'b1;
                    beats_left_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            beats_left_q    <= '0;
            prev_hi_q       <= '0;
            output_valid_o  <= 1'b0;
            data_o          <= '0;
            packet_type_o   <= '0;
            packet_length_o <= '0;
            frame_start_o   <= 1'b0;
            frame_end_o     <= 1'b0;
            ecc_error_o     <= 1'b0;
            packet_error_o  <= 1'b0;
        end else begin
            beats_left_q    <= beats_left_d;
            output_valid_o  <= out_vld_d;
            data_o          <= out_dat_d;
            packet_type_o   <= type_d;
            packet_length_o <= len_d;
            frame_start_o   <= fs_d;
            frame_end_o     <= fe_d;
            ecc_error_o     <= ecc_err_d;
            packet_error_o  <= pkt_err_d;
            if (data_valid_i) begin
                prev_hi_q <= data_i[63:32];
            end
        end
    end

endmodule

// File: tb/tb_mipi_csi_rx_packet_decoder_2lane.sv
// Randomized scoreboard bench for the CSI-2 RX packet decoder.
`timescale 1ns/1ps
module tb_mipi_csi_rx_packet_decoder_2lane;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        data_valid_i;
    logic [63:0] data_i;
    logic        output_valid_o;
    logic [63:0] data_o;
    logic [2:0]  packet_type_o;
    logic [15:0] packet_length_o;
    logic        frame_start_o, frame_end_o, ecc_error_o, packet_error_o;

    mipi_csi_rx_packet_decoder_2lane dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .data_valid_i    (data_valid_i),
        .data_i          (data_i),
        .output_valid_o  (output_valid_o),
        .data_o          (data_o),
        .packet_type_o   (packet_type_o),
        .packet_length_o (packet_length_o),
        .frame_start_o   (frame_start_o),
        .frame_end_o     (frame_end_o),
        .ecc_error_o     (ecc_error_o),
        .packet_error_o  (packet_error_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Syndrome column of each header bit in the CSI-2 Hamming code.
    localparam logic [5:0] ECC_COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
        6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    localparam logic [4:0] K_BEAT = 5'b10000;
    localparam logic [4:0] K_FS   = 5'b01000;
    localparam logic [4:0] K_FE   = 5'b00100;
    localparam logic [4:0] K_ECC  = 5'b00010;
    localparam logic [4:0] K_PERR = 5'b00001;

    typedef struct {
        int          cyc;
        logic [4:0]  kind;
        logic [63:0] dat;
        logic [63:0] mask;
        logic [2:0]  typ;
        logic [15:0] len;
    } ev_t;

    ev_t         exp_q[$];
    logic [2:0]  lat_typ = '0;
    logic [15:0] lat_len = '0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        done = 1'b0;

    function automatic logic [7:0] ref_ecc(input logic [23:0] d);
        logic [5:0] p;
        p = '0;
        for (int i = 0; i < 24; i++) if (d[i]) p ^= ECC_COL[i];
        return {2'b00, p};
    endfunction

    task automatic push_ev(input int c, input logic [4:0] k, input logic [63:0] d, input logic [63:0] m);
        ev_t e;
        e.cyc = c; e.kind = k; e.dat = d; e.mask = m; e.typ = lat_typ; e.len = lat_len;
        exp_q.push_back(e);
    endtask

    // Drives one packet of nb valid beats; abort_at >= 0 asserts reset while that beat is on the bus.
    task automatic send_pkt(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] flip,
                            input int nb, input int gap, input int abort_at);
        logic [7:0]  s[$];
        logic [63:0] d, m;
        int          n0, need;
        s = {};
        s.push_back(di); s.push_back(wc[7:0]); s.push_back(wc[15:8]);
        s.push_back(ref_ecc({wc, di}) ^ flip);
        for (int i = 4; i < nb * 8; i++) s.push_back(8'($urandom));
        @(negedge clk_i);
        n0 = cyc;
        if (flip != 8'h00) begin
            push_ev(n0 + 1, K_ECC, '0, '0);
        end else if (di[5:0] == 6'h00) begin
            push_ev(n0 + 1, K_FS, '0, '0);
        end else if (di[5:0] == 6'h01) begin
            push_ev(n0 + 1, K_FE, '0, '0);
        end else if (di[5:0] >= 6'h2A && di[5:0] <= 6'h2D && wc != 16'd0) begin
            lat_typ = di[2:0];
            lat_len = wc;
            need = (int'(wc) + 7) / 8;
            for (int j = 0; j < need; j++) begin
                if (j < nb - 1 || j == nb - 1 && j == need - 1) begin
                    for (int k = 0; k < 8; k++) begin
                        if (j < nb - 1 || k < 4) begin
                            d[8*k +: 8] = s[4 + 8*j + k];
                            m[8*k +: 8] = (8*j + k < int'(wc)) ? 8'hFF : 8'h00;
                        end else begin
                            d[8*k +: 8] = 8'h00;
                            m[8*k +: 8] = 8'hFF;
                        end
                    end
                    push_ev(n0 + 2 + j, K_BEAT, d, m);
                end else begin
                    push_ev(n0 + nb + 1, K_PERR, '0, '0);
                    break;
                end
            end
        end
        for (int b = 0; b < nb; b++) begin
            if (b > 0) @(negedge clk_i);
            data_valid_i = 1'b1;
            for (int k = 0; k < 8; k++) data_i[8*k +: 8] = s[8*b + k];
            if (b == abort_at) begin
                #2;
                reset_n_i    = 1'b0;
                data_valid_i = 1'b0;
                lat_typ      = '0;
                lat_len      = '0;
                repeat (2) @(negedge clk_i);
                reset_n_i = 1'b1;
                return;
            end
        end
        @(negedge clk_i);
        data_valid_i = 1'b0;
        data_i       = {$urandom, $urandom};
        repeat (gap - 1) @(negedge clk_i);
    endtask

    initial begin
        logic [5:0]  dt;
        logic [7:0]  di;
        logic [15:0] wc;
        int          need, nb;
        reset_n_i    = 1'b1;
        data_valid_i = 1'b0;
        data_i       = '0;
        #1 reset_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;

        send_pkt(8'h2B, 16'd40, 8'h00, 6, 1, -1);
        send_pkt(8'h2C, 16'd12, 8'h00, 2, 1, -1);
        send_pkt(8'h00, 16'h0005, 8'h00, 1, 1, -1);
        send_pkt(8'h01, 16'h0005, 8'h00, 1, 2, -1);
        send_pkt(8'h2B, 16'd40, 8'h01, 6, 1, -1);
        send_pkt(8'h6A, 16'd24, 8'h00, 5, 2, -1);
        send_pkt(8'h2D, 16'd64, 8'h00, 4, 1, -1);
        send_pkt(8'h2D, 16'd64, 8'h00, 9, 1, 3);
        send_pkt(8'h2B, 16'd40, 8'h00, 6, 1, -1);
        send_pkt(8'h12, 16'd8, 8'h00, 3, 1, -1);

        for (int p = 0; p < 80; p++) begin
            case ($urandom_range(0, 9))
                0:       dt = 6'h00;
                1:       dt = 6'h01;
                2:       dt = 6'h12;
                3:       dt = 6'h30;
                default: dt = 6'h2A + 6'($urandom_range(0, 3));
            endcase
            di = {2'($urandom_range(0, 3)), dt};
            if (dt >= 6'h2A) begin
                wc = 16'($urandom_range(0, 70));
            end else begin
                wc = 16'($urandom);
            end
            need = (int'(wc) + 7) / 8;
            if (dt < 6'h2A || wc == 16'd0) begin
                nb = $urandom_range(1, 3);
            end else if ($urandom_range(0, 2) == 0) begin
                nb = $urandom_range(1, need + 2);
            end else begin
                nb = need + 1 + $urandom_range(0, 1);
            end
            send_pkt(di, wc, ($urandom_range(0, 7) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00,
                     nb, $urandom_range(1, 3), -1);
        end
        repeat (10) @(negedge clk_i);
        done = 1'b1;
    end

    initial begin
        ev_t        e;
        logic [4:0] obs;
        forever begin
            @(negedge clk_i or negedge reset_n_i);
            #1;
            if (!reset_n_i) begin
                n_chk++;
                if ({output_valid_o, data_o, packet_type_o, packet_length_o,
                     frame_start_o, frame_end_o, ecc_error_o, packet_error_o} !== '0) begin
                    n_fail++;
                    $display("FAIL reset_outputs: got vld=%b dat=%h typ=%0d len=%0d fs=%b fe=%b ecc=%b perr=%b, required all 0",
                             output_valid_o, data_o, packet_type_o, packet_length_o,
                             frame_start_o, frame_end_o, ecc_error_o, packet_error_o);
                end
                exp_q.delete();
            end else begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL missing_event: kind=%b due at cycle %0d, nothing seen by cycle %0d",
                             exp_q[0].kind, exp_q[0].cyc, cyc);
                    exp_q.delete(0);
                end
                obs = {output_valid_o, frame_start_o, frame_end_o, ecc_error_o, packet_error_o};
                if (obs != 5'b0) begin
                    n_chk++;
                    if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                        n_fail++;
                        $display("FAIL unexpected_output: got kind=%b at cycle %0d, required none", obs, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (obs != e.kind) begin
                            n_fail++;
                            $display("FAIL event_kind: got %b at cycle %0d, required %b", obs, cyc, e.kind);
                        end
                        n_chk++;
                        if (packet_type_o != e.typ || packet_length_o != e.len) begin
                            n_fail++;
                            $display("FAIL type_len: got type=%0d len=%0d at cycle %0d, required type=%0d len=%0d",
                                     packet_type_o, packet_length_o, cyc, e.typ, e.len);
                        end
                        if (e.kind == K_BEAT) begin
                            n_chk++;
                            if (((data_o ^ e.dat) & e.mask) != 64'h0) begin
                                n_fail++;
                                $display("FAIL beat_data: got %h at cycle %0d, required %h (byte mask %h)",
                                         data_o, cyc, e.dat, e.mask);
                            end
                        end
                    end
                end
                if (done) begin
                    n_chk++;
                    if (exp_q.size() != 0) begin
                        n_fail++;
                        $display("FAIL leftover_events: got %0d still pending, required 0", exp_q.size());
                    end
                    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                    $finish;
                end
            end
        end
    end

endmodule

// File: doc/mipi_csi_rx_packet_decoder_2lane.md
MIPI_CSI_RX_PACKET_DECODER_2LANE -- requirements
Module: mipi_csi_rx_packet_decoder_2lane

Interface
REQ-001 clk_i  input  1  byte/word clock; all logic on rising edge.
REQ-002 reset_n_i  input  1  reset, asynchronous, active-low.
REQ-003 data_valid_i  input  1  aligned lane data valid; high for one contiguous burst per packet.
REQ-004 data_i  input  64  8 aligned bytes per clock; byte k at bits [8k+7:8k], byte 0 first on wire.
REQ-005 output_valid_o  output  1  payload beat valid; drives depacker data_valid.
REQ-006 data_o  output  64  8 payload bytes, payload byte 8j+k at bits [8k+7:8k] of beat j.
REQ-007 packet_type_o  output  3  DataID[2:0] of the current long packet.
REQ-008 packet_length_o  output  16  word count (bytes) of the current long packet.
REQ-009 frame_start_o / frame_end_o  output  1 each  one-cycle pulse on FS (0x00) / FE (0x01) short packet.
REQ-010 ecc_error_o / packet_error_o  output  1 each  one-cycle pulse on header ECC mismatch / truncated payload.

Function
REQ-011 The header shall be bytes 0..3 of the first valid beat: DI, WC[7:0], WC[15:8], ECC.
REQ-012 Header ECC shall be recomputed over the 24 header bits (CSI-2 6-bit Hamming, ECC[7:6]=0) and compared to byte 3; detection only, no correction.
REQ-013 FSM states: IDLE, PAYLOAD, SKIP.
REQ-014 IDLE + data_valid_i=1: ECC bad -> pulse ecc_error_o, go SKIP; DI[5:0]=0x00/0x01 -> pulse frame_start_o/frame_end_o next cycle, go SKIP; DI[5:0] in {0x2A,0x2B,0x2C,0x2D} and WC!=0 -> latch packet_type_o, packet_length_o, beats_left=(WC+7)>>3, go PAYLOAD; otherwise go SKIP.
REQ-015 Payload realignment: output beat = {current data_i[31:0], previous data_i[63:32]}, registered; first payload beat appears 2 cycles after the header beat.
REQ-016 In PAYLOAD each valid input beat shall emit one output beat and decrement beats_left; at beats_left 1->0 go SKIP.
REQ-017 data_valid_i falls in PAYLOAD with beats_left=1: emit final beat next cycle as {32'h0, previous upper half}, go IDLE.
REQ-018 data_valid_i falls in PAYLOAD with beats_left>1: no further output, pulse packet_error_o, go IDLE.
REQ-019 SKIP shall discard beats (CRC, padding, unsupported packets) until data_valid_i=0, then IDLE.
REQ-020 Bytes past WC in the final beat are don't-care; downstream uses packet_length_o.
REQ-021 output_valid_o shall be high exactly ceil(WC/8) cycles per accepted packet, contiguous when data_valid_i is contiguous.
REQ-022 packet_type_o/packet_length_o shall be held from acceptance until the next accepted long packet.
REQ-023 Back-to-back packets require data_valid_i low >=1 cycle; a new header is recognised only from IDLE.

Reset
REQ-024 reset_n_i low shall asynchronously force IDLE, beats_left=0, every output and the previous-beat register to 0.
REQ-025 Reset mid-packet shall discard the packet; after release the first data_valid_i rising edge is treated as a header.

Structure
REQ-026 Package mipi_csi_pkg shall hold DataID constants (FS 0x00, FE 0x01, RAW8 0x2A, RAW10 0x2B, RAW12 0x2C, RAW14 0x2D), header byte positions, the state type.
REQ-027 ECC computation shall be sub-module mipi_csi_ecc_check (combinational, 24-bit in, 6-bit out, match flag).

Verification
REQ-028 RAW10 DI=0x2B WC=40, valid ECC, 6 valid beats -> output_valid_o high cycles N+2..N+6 (5 beats), beat 0 = payload bytes 0..7, packet_type_o=3'b011, packet_length_o=40.
REQ-029 RAW12 DI=0x2C WC=12, data_valid_i high 2 beats -> 2 output beats, second = {32'h0, bytes 8..11}, no packet_error_o.
REQ-030 FS short packet DI=0x00, valid ECC, 1 beat -> frame_start_o single pulse at N+1, output_valid_o stays 0.
REQ-031 DI=0x2B WC=40 with ECC byte bit 0 flipped -> ecc_error_o pulse, no output beats, next good packet decoded normally.
REQ-032 DI=0x2D WC=64, data_valid_i drops after 4 beats -> 3 output beats, packet_error_o pulse, FSM in IDLE.
REQ-033 reset_n_i asserted during PAYLOAD beat 3 -> all outputs 0 immediately, following packet decoded correctly.
